life_gen_scheduler: RTL and testbench
=====================================

// Module: life_gen_scheduler
// PURPOSE
//  Owns the Game-of-Life board and sequences its generation updates. Detects frame ticks on vsync,
//  divides them to a programmable generation rate, and runs a row-serial update engine into a
//  back buffer, then swaps buffers atomically. The VGA renderer reads the front buffer at any time;
//  the update engine, loader and renderer never contend for the same buffer.
// PARAMETERS
//  BOARD_W      8  cells per row (bits per row word)
//  BOARD_H      8  rows; ROW_AW = $clog2(BOARD_H)
//  FRAME_DIV_W  6  width of frame_div
// PORTS
//  clk        in   1            pixel clock
//  reset      in   1            synchronous, active-high
//  vsync      in   1            from vga_synchronization; rising edge = frame tick
//  run        in   1            1 = free-running generations
//  step       in   1            1-cycle pulse: one generation, honoured only when run=0
//  frame_div  in   FRAME_DIV_W  one generation every frame_div+1 ticks
//  load_en    in   1            write load_data into front row load_row
//  load_row   in   ROW_AW       load address
//  load_data  in   BOARD_W      row word, bit c = column c
//  rd_row     in   ROW_AW       renderer read address
//  rd_data    out  BOARD_W      front row rd_row, combinational
//  busy       out  1            engine in COMPUTE or SWAP
//  gen_done   out  1            1-cycle pulse when new generation becomes visible
//  gen_count  out  16           generations completed, wraps 0xFFFF->0
//  overrun    out  1            sticky: frame tick arrived while busy
// BEHAVIOUR
//  Reset (synchronous): both buffers all-0, front_sel=0, frame_cnt=0, state IDLE, busy=0,
//   gen_done=0, gen_count=0, overrun=0, vsync_q=0 (so rd_data=0).
//  Tick = vsync & ~vsync_q (vsync_q registered each clk); tick asserts the cycle after the edge.
//  States: IDLE -> COMPUTE -> SWAP -> IDLE.
//  IDLE: on tick with run=1: if frame_cnt==frame_div {frame_cnt<=0; go COMPUTE} else frame_cnt++.
//   Tick with run=0: frame_cnt unchanged. step=1 & run=0 -> COMPUTE next cycle. step with run=1 ignored.
//   Tick and step same cycle with run=0: step wins (one generation).
//  COMPUTE: row counter r=0..BOARD_H-1, one row per clk; back[r] = rule(front[r-1],front[r],front[r+1]).
//   Rule: live & (2|3 neighbours) -> live; dead & 3 neighbours -> live; else dead. Neighbour count 4-bit.
//   After r==BOARD_H-1 -> SWAP.
//  SWAP (1 clk): front_sel toggles, gen_count++, gen_done=1 for this cycle; -> IDLE.
//  Latency: start decision to gen_done = BOARD_H+1 clks; rd_data shows new board the cycle after gen_done.
//  Tick while busy: dropped, frame_cnt not advanced, overrun<=1 (cleared only by reset).
//  load_en: honoured only in IDLE; writes front[load_row] same clk; ignored while busy.
//   load_en and a start in the same IDLE cycle: load applied first; compute sees loaded row.
//  frame_div changed mid-count: new value compared from next tick; if frame_cnt>frame_div,
//   frame_cnt counts up to wrap then matches (no special handling).
//  Reset mid-COMPUTE: abort, back buffer discarded, all state per reset list.
// CONFIGURATION
//  LIFE_TORUS_EN defined: edges wrap (row -1 = row BOARD_H-1, column -1 = column BOARD_W-1, and
//   vice versa). Undefined: cells outside the board are permanently dead.
// TESTING
//  Reset, load blinker rows 3..5 = 8'h10 each, run=1, frame_div=0, vsync edge -> after 9 clks
//   gen_done, front rows 3,5=0, row 4=8'h38; next gen restores rows 3..5=8'h10; gen_count=2.
//  frame_div=3, run=1, 8 vsync edges -> exactly 2 gen_done pulses, on ticks 4 and 8.
//  run=0, 5 vsync edges -> no gen_done; one step pulse -> one gen_done, gen_count+1.
//  Start compute, pulse load_en row 0 data 8'hFF mid-COMPUTE -> ignored; force tick while busy
//   -> overrun=1, frame_cnt unchanged.
//  Assert reset at COMPUTE r=4 -> next clk busy=0, rd_data=0 for all rows, gen_count=0.
//  Glider heading to row 7/col 7: without LIFE_TORUS_EN dies into 2x2 block at corner;
//   with LIFE_TORUS_EN reappears at row 0/col 0 after 4 generations per cell shift.

Source files
------------

// File: rtl/life_gen_scheduler.sv
// Game-of-Life board owner: double-buffered board, vsync-divided generation scheduler and row-serial update engine.
// Optional build macro LIFE_TORUS_EN wraps the board edges; without it cells outside the board are dead.
`timescale 1ns/1ps
module life_gen_scheduler #(
  parameter int BOARD_W     = 8,
  parameter int BOARD_H     = 8,
  parameter int FRAME_DIV_W = 6,
  localparam int ROW_AW     = $clog2(BOARD_H)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   vsync,
  input  logic                   run,
  input  logic                   step,
  input  logic [FRAME_DIV_W-1:0] frame_div,
  input  logic                   load_en,
  input  logic [ROW_AW-1:0]      load_row,
  input  logic [BOARD_W-1:0]     load_data,
  input  logic [ROW_AW-1:0]      rd_row,
  output logic [BOARD_W-1:0]     rd_data,
  output logic                   busy,
  output logic                   gen_done,
  output logic [15:0]            gen_count,
  output logic                   overrun
);

  localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(BOARD_H - 1);

  typedef enum logic [1:0] {IDLE, COMPUTE, SWAP} state_t;

  state_t                   state_q, state_d;
  logic [BOARD_W-1:0]       board [2][BOARD_H];
  logic                     front_sel;
  logic                     vsync_q;
  logic                     tick;
  logic [FRAME_DIV_W-1:0]   frame_cnt;
  logic [ROW_AW-1:0]        row;
  logic                     start, cnt_clr, cnt_inc;
  logic [BOARD_W-1:0]       up_row, cur_row, dn_row, next_row;

  // One row of the Life rule; padded bit i holds column i-1 so every cell sees a full 3x3 window.
  function automatic logic [BOARD_W-1:0] life_row(input logic [BOARD_W-1:0] up,
                                                  input logic [BOARD_W-1:0] cur,
                                                  input logic [BOARD_W-1:0] dn);
    logic [BOARD_W+1:0] pu, pc, pd;
    logic [3:0]         n;
    logic [BOARD_W-1:0] res;
    res = '0;
`ifdef LIFE_TORUS_EN
    pu = {up[0],  up,  up[BOARD_W-1]};
    pc = {cur[0], cur, cur[BOARD_W-1]};
    pd = {dn[0],  dn,  dn[BOARD_W-1]};
`else
    pu = {1'b0, up,  1'b0};
    pc = {1'b0, cur, 1'b0};
    pd = {1'b0, dn,  1'b0};
`endif
    for (int c = 0; c < BOARD_W; c++) begin
      n = 4'(pu[c]) + 4'(pu[c+1]) + 4'(pu[c+2]) +
          4'(pc[c]) + 4'(pc[c+2]) +
          4'(pd[c]) + 4'(pd[c+1]) + 4'(pd[c+2]);
      res[c] = (n == 4'd3) | (cur[c] & (n == 4'd2));
    end
    return res;
  endfunction

  assign tick     = vsync & ~vsync_q;
  assign rd_data  = board[front_sel][rd_row];
  assign busy     = (state_q != IDLE);
  assign gen_done = (state_q == SWAP);

  always_comb begin
    cur_row = board[front_sel][row];
`ifdef LIFE_TORUS_EN
    up_row  = board[front_sel][(row == '0) ? LAST_ROW : row - ROW_AW'(1)];
    dn_row  = board[front_sel][(row == LAST_ROW) ? '0 : row + ROW_AW'(1)];
`else
    up_row  = (row == '0) ? '0 : board[front_sel][row - ROW_AW'(1)];
    dn_row  = (row == LAST_ROW) ? '0 : board[front_sel][row + ROW_AW'(1)];
`endif
    next_row = life_row(up_row, cur_row, dn_row);
  end

  // A step request with run=0 takes priority over a coincident tick.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (step && !run) begin
          start = 1'b1;
        end else if (tick && run) begin
          if (frame_cnt == frame_div) begin
            start   = 1'b1;
            cnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        if (start) state_d = COMPUTE;
      end
      COMPUTE: if (row == LAST_ROW) state_d = SWAP;
      SWAP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Loader writes only the front buffer in IDLE; the engine writes only the back buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < BOARD_H; r++) begin
        board[0][r] <= '0;
        board[1][r] <= '0;
      end
      front_sel <= 1'b0;
      vsync_q   <= 1'b0;
      frame_cnt <= '0;
      row       <= '0;
      gen_count <= '0;
      overrun   <= 1'b0;
    end else begin
      vsync_q <= vsync;
      if (state_q == IDLE && load_en) board[front_sel][load_row] <= load_data;
      if (state_q == COMPUTE)         board[~front_sel][row]     <= next_row;
      if (cnt_clr)      frame_cnt <= '0;
      else if (cnt_inc) frame_cnt <= frame_cnt + FRAME_DIV_W'(1);
      if (start)                   row <= '0;
      else if (state_q == COMPUTE) row <= row + ROW_AW'(1);
      if (state_q == SWAP) begin
        front_sel <= ~front_sel;
        gen_count <= gen_count + 16'd1;
      end
      if (tick && state_q != IDLE) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_life_gen_scheduler.sv
// Self-checking bench for life_gen_scheduler against a cell-by-cell Life model and a tick-counting schedule model.
`timescale 1ns/1ps
module tb_life_gen_scheduler;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int FW = 6;

  logic          clk = 1'b0;
  logic          reset, vsync, run, step, load_en;
  logic [FW-1:0] frame_div;
  logic [2:0]    load_row, rd_row;
  logic [7:0]    load_data, rd_data;
  logic          busy, gen_done, overrun;
  logic [15:0]   gen_count;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  model [H];
  logic [15:0] exp_count;

  life_gen_scheduler #(.BOARD_W(W), .BOARD_H(H), .FRAME_DIV_W(FW)) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .run(run), .step(step),
    .frame_div(frame_div), .load_en(load_en), .load_row(load_row),
    .load_data(load_data), .rd_row(rd_row), .rd_data(rd_data),
    .busy(busy), .gen_done(gen_done), .gen_count(gen_count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  // Reference Life step: count the eight neighbours of every cell directly.
  task automatic model_step();
    logic [7:0] nxt [H];
    int n, rr, cc;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
`ifdef LIFE_TORUS_EN
            rr = (rr + H) % H;
            cc = (cc + W) % W;
`endif
            if ((dr != 0 || dc != 0) && rr >= 0 && rr < H && cc >= 0 && cc < W)
              n += int'(model[rr][cc]);
          end
        end
        nxt[r][c] = (n == 3) || (model[r][c] && n == 2);
      end
    end
    for (int r = 0; r < H; r++) model[r] = nxt[r];
  endtask

  task automatic do_reset();
    reset = 1'b1; vsync = 1'b0; run = 1'b0; step = 1'b0; load_en = 1'b0;
    frame_div = '0; load_row = '0; load_data = '0; rd_row = '0;
    clk1(); clk1();
    reset = 1'b0;
    for (int r = 0; r < H; r++) model[r] = 8'h00;
    exp_count = 16'd0;
  endtask

  task automatic random_model();
    for (int r = 0; r < H; r++) model[r] = 8'($urandom);
  endtask

  task automatic load_model();
    for (int r = 0; r < H; r++) begin
      load_en = 1'b1; load_row = 3'(r); load_data = model[r];
      clk1();
    end
    load_en = 1'b0;
  endtask

  // Drive vsync edge and/or step pulse for one cycle, then watch gen_done for a bounded window.
  task automatic stim(input bit v, input bit s, input int budget, output int lat, output int pulses);
    vsync = v; step = s; lat = -1; pulses = 0;
    for (int i = 1; i <= budget; i++) begin
      clk1();
      vsync = 1'b0; step = 1'b0; load_en = 1'b0;
      if (gen_done === 1'b1) begin
        pulses++;
        if (lat < 0) lat = i;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (gen_done !== 1'b0) begin errors++; $display("FAIL reset_gen_done: got %b expected 0", gen_done); end
    checks++; if (gen_count !== 16'd0) begin errors++; $display("FAIL reset_gen_count: got %h expected 0", gen_count); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    for (int r = 0; r < H; r++) begin
      rd_row = 3'(r); #1;
      checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd row %0d: got %h expected 00", r, rd_data); end
    end
  endtask

  task automatic test_blinker();
    int lat, p;
    do_reset();
    model[3] = 8'h10; model[4] = 8'h10; model[5] = 8'h10;
    load_model();
    run = 1'b1; frame_div = '0;
    stim(1'b1, 1'b0, 20, lat, p);
    checks++; if (lat !== 9) begin errors++; $display("FAIL blinker_latency: got %0d expected 9", lat); end
    model_step(); exp_count++;
    rd_row = 3'd4; #1;
    checks++; if (rd_data !== 8'h38) begin errors++; $display("FAIL blinker_row4: got %h expected 38", rd_data); end
    for (int r = 0; r < H; r++) begin
      rd_row = 3'(r); #1;
      checks++; if (rd_data !== model[r]) begin errors++; $display("FAIL blinker_gen1 row %0d: got %h expected %h", r, rd_data, model[r]); end
    end
    stim(1'b1, 1'b0, 20, lat, p);
    model_step(); exp_count++;
    for (int r = 0; r < H; r++) begin
      rd_row = 3'(r); #1;
      checks++; if (rd_data !== model[r]) begin errors++; $display("FAIL blinker_gen2 row %0d: got %h expected %h", r, rd_data, model[r]); end
    end
    checks++; if (gen_count !== 16'd2) begin errors++; $display("FAIL blinker_count: got %0d expected 2", gen_count); end
    run = 1'b0;
  endtask

  task automatic test_frame_div();
    int lat, p, fd;
    for (int trial = 0; trial < 3; trial++) begin
      do_reset();
      fd = (trial == 0) ? 3 : int'($urandom_range(0, 4));
      random_model();
      load_model();
      run = 1'b1; frame_div = FW'(fd);
      for (int k = 1; k <= 8; k++) begin
        stim(1'b1, 1'b0, 14, lat, p);
        checks++;
        if (p !== ((k % (fd + 1) == 0) ? 1 : 0)) begin
          errors++;
          $display("FAIL frame_div %0d tick %0d: got %0d pulses expected %0d", fd, k, p, (k % (fd + 1) == 0) ? 1 : 0);
        end
        if (k % (fd + 1) == 0) begin model_step(); exp_count++; end
      end
      checks++; if (gen_count !== exp_count) begin errors++; $display("FAIL frame_div_count: got %0d expected %0d", gen_count, exp_count); end
      for (int r = 0; r < H; r++) begin
        rd_row = 3'(r); #1;
        checks++; if (rd_data !== model[r]) begin errors++; $display("FAIL frame_div_board row %0d: got %h expected %h", r, rd_data, model[r]); end
      end
      run = 1'b0;
    end
  endtask

  task automatic test_step();
    int lat, p, r0;
    do_reset();
    random_model();
    load_model();
    run = 1'b0; frame_div = FW'($urandom_range(0, 3));
    for (int k = 0; k < 5; k++) begin
      stim(1'b1, 1'b0, 12, lat, p);
      checks++; if (p !== 0) begin errors++; $display("FAIL run0_tick %0d: got %0d pulses expected 0", k, p); end
    end
    stim(1'b0, 1'b1, 20, lat, p);
    checks++; if (p !== 1 || lat !== 9) begin errors++; $display("FAIL step_pulse: got %0d pulses lat %0d expected 1 lat 9", p, lat); end
    model_step(); exp_count++;
    checks++; if (gen_count !== exp_count) begin errors++; $display("FAIL step_count: got %0d expected %0d", gen_count, exp_count); end
    run = 1'b1;
    stim(1'b0, 1'b1, 20, lat, p);
    checks++; if (p !== 0) begin errors++; $display("FAIL step_while_run: got %0d pulses expected 0", p); end
    run = 1'b0;
    stim(1'b1, 1'b1, 20, lat, p);
    checks++; if (p !== 1) begin errors++; $display("FAIL step_and_tick: got %0d pulses expected 1", p); end
    model_step(); exp_count++;
    r0 = int'($urandom_range(0, H - 1));
    model[r0] = 8'($urandom);
    load_en = 1'b1; load_row = 3'(r0); load_data = model[r0];
    stim(1'b0, 1'b1, 20, lat, p);
    checks++; if (p !== 1) begin errors++; $display("FAIL load_and_step: got %0d pulses expected 1", p); end
    model_step(); exp_count++;
    for (int r = 0; r < H; r++) begin
      rd_row = 3'(r); #1;
      checks++; if (rd_data !== model[r]) begin errors++; $display("FAIL step_board row %0d: got %h expected %h", r, rd_data, model[r]); end
    end
    checks++; if (gen_count !== exp_count) begin errors++; $display("FAIL step_count_end: got %0d expected %0d", gen_count, exp_count); end
  endtask

  task automatic test_busy();
    int lat, p;
    do_reset();
    random_model();
    load_model();
    run = 1'b0; frame_div = FW'(1);
    step = 1'b1; clk1(); step = 1'b0;
    run = 1'b1;
    clk1(); clk1();
    load_en = 1'b1; load_row = 3'd0; load_data = 8'hFF; clk1(); load_en = 1'b0;
    vsync = 1'b1; clk1(); vsync = 1'b0;
    clk1();
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL busy_overrun: got %b expected 1", overrun); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_flag: got %b expected 1", busy); end
    p = 0;
    for (int i = 0; i < 20; i++) begin
      clk1();
      if (gen_done === 1'b1) p++;
    end
    checks++; if (p !== 1) begin errors++; $display("FAIL busy_gen: got %0d pulses expected 1", p); end
    model_step(); exp_count++;
    for (int r = 0; r < H; r++) begin
      rd_row = 3'(r); #1;
      checks++; if (rd_data !== model[r]) begin errors++; $display("FAIL busy_board row %0d: got %h expected %h", r, rd_data, model[r]); end
    end
    stim(1'b1, 1'b0, 14, lat, p);
    checks++; if (p !== 0) begin errors++; $display("FAIL busy_framecnt_tick1: got %0d pulses expected 0", p); end
    stim(1'b1, 1'b0, 14, lat, p);
    checks++; if (p !== 1) begin errors++; $display("FAIL busy_framecnt_tick2: got %0d pulses expected 1", p); end
    model_step(); exp_count++;
    checks++; if (gen_count !== exp_count) begin errors++; $display("FAIL busy_count: got %0d expected %0d", gen_count, exp_count); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL busy_overrun_sticky: got %b expected 1", overrun); end
    run = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat, p;
    do_reset();
    random_model();
    load_model();
    run = 1'b0;
    stim(1'b0, 1'b1, 14, lat, p);
    step = 1'b1; clk1(); step = 1'b0;
    vsync = 1'b1; clk1(); vsync = 1'b0;
    clk1(); clk1(); clk1();
    checks++; if (busy !== 1'b1 || overrun !== 1'b1) begin errors++; $display("FAIL midreset_pre: got busy %b overrun %b expected 1 1", busy, overrun); end
    reset = 1'b1; clk1(); reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    checks++; if (gen_count !== 16'd0) begin errors++; $display("FAIL midreset_count: got %0d expected 0", gen_count); end
    checks++; if (overrun !== 1'b0 || gen_done !== 1'b0) begin errors++; $display("FAIL midreset_flags: got overrun %b gen_done %b expected 0 0", overrun, gen_done); end
    for (int r = 0; r < H; r++) begin
      rd_row = 3'(r); #1;
      checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL midreset_rd row %0d: got %h expected 00", r, rd_data); end
    end
  endtask

  task automatic test_glider();
    int lat, p;
    do_reset();
    model[0] = 8'h02; model[1] = 8'h04; model[2] = 8'h07;
    load_model();
    run = 1'b0;
    for (int g = 1; g <= 32; g++) begin
      stim(1'b0, 1'b1, 12, lat, p);
      checks++; if (p !== 1) begin errors++; $display("FAIL glider_gen %0d: got %0d pulses expected 1", g, p); end
      model_step(); exp_count++;
      for (int r = 0; r < H; r++) begin
        rd_row = 3'(r); #1;
        checks++; if (rd_data !== model[r]) begin errors++; $display("FAIL glider gen %0d row %0d: got %h expected %h", g, r, rd_data, model[r]); end
      end
      if (g == 4) begin
        rd_row = 3'd2; #1;
        checks++; if (rd_data !== 8'h08) begin errors++; $display("FAIL glider_shift row 2: got %h expected 08", rd_data); end
        rd_row = 3'd3; #1;
        checks++; if (rd_data !== 8'h0E) begin errors++; $display("FAIL glider_shift row 3: got %h expected 0e", rd_data); end
      end
`ifdef LIFE_TORUS_EN
      if (g == 32) begin
        rd_row = 3'd2; #1;
        checks++; if (rd_data !== 8'h07) begin errors++; $display("FAIL glider_wrap row 2: got %h expected 07", rd_data); end
      end
`endif
    end
    checks++; if (gen_count !== exp_count) begin errors++; $display("FAIL glider_count: got %0d expected %0d", gen_count, exp_count); end
  endtask

  task automatic test_random();
    int lat, p;
    for (int b = 0; b < 4; b++) begin
      do_reset();
      random_model();
      load_model();
      for (int g = 0; g < 3; g++) begin
        stim(1'b0, 1'b1, 12, lat, p);
        model_step(); exp_count++;
      end
      for (int r = 0; r < H; r++) begin
        rd_row = 3'(r); #1;
        checks++; if (rd_data !== model[r]) begin errors++; $display("FAIL random board %0d row %0d: got %h expected %h", b, r, rd_data, model[r]); end
      end
      checks++; if (gen_count !== exp_count) begin errors++; $display("FAIL random_count %0d: got %0d expected %0d", b, gen_count, exp_count); end
    end
  endtask

  initial begin
    test_reset();
    test_blinker();
    test_frame_div();
    test_step();
    test_busy();
    test_reset_mid();
    test_glider();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
